// File: rtl/pg_bus_reader.sv
// Receive-side sequencer for a single-wire pass-gate line: issues a low start bit,
// releases the line, then samples WIDTH response bits MSB first.
module pg_bus_reader #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned BITCYC = 4,
    parameter int unsigned SAMPLE = 2,
    parameter int unsigned TURN   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RD_REQ,
    output logic             RD_BUSY,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             GATE_N,
    output logic             GATE_P,
    output logic             DRV,
    input  logic             BUS_IN
);

    localparam int unsigned CW = (BITCYC > 1) ? $clog2(BITCYC) : 1;
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned TW = (TURN > 1) ? $clog2(TURN) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_TURN  = 3'd2;
    localparam logic [2:0] S_RECV  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    scnt_q, scnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [WIDTH-1:0] dout_d;
    logic             dvalid_d;
    logic             slot_end;

    // Next-state, counter and data-path decode
    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bcnt_d   = bcnt_q;
        tcnt_d   = tcnt_q;
        dout_d   = DOUT;
        dvalid_d = DVALID;
        slot_end = (scnt_q == CW'(BITCYC - 1));
        case (state_q)
            S_IDLE: begin
                if (RD_REQ) begin
                    state_d = S_START;
                    scnt_d  = '0;
                end
            end
            S_START: begin
                if (slot_end) begin
                    scnt_d  = '0;
                    tcnt_d  = '0;
                    state_d = S_TURN;
                end else begin
                    scnt_d = scnt_q + CW'(1);
                end
            end
            S_TURN: begin
                bcnt_d = '0;
                if (tcnt_q == TW'(TURN - 1)) begin
                    tcnt_d  = '0;
                    scnt_d  = '0;
                    state_d = S_RECV;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_RECV: begin
                if (scnt_q == CW'(SAMPLE)) begin
                    dout_d = WIDTH'({DOUT, BUS_IN});
                end
                if (slot_end) begin
                    scnt_d = '0;
                    if (bcnt_q == BW'(WIDTH - 1)) begin
                        bcnt_d   = '0;
                        state_d  = S_DONE;
                        dvalid_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end else begin
                    scnt_d = scnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (DREADY) begin
                    state_d  = S_IDLE;
                    dvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; gate pins follow the next state so they switch on the transition edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            DOUT    <= '0;
            DVALID  <= 1'b0;
            RD_BUSY <= 1'b0;
            GATE_N  <= 1'b0;
            GATE_P  <= 1'b1;
            DRV     <= 1'b1;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            DOUT    <= dout_d;
            DVALID  <= dvalid_d;
            RD_BUSY <= (state_d != S_IDLE);
            GATE_N  <= (state_d == S_START);
            GATE_P  <= (state_d != S_START);
            DRV     <= (state_d != S_START);
        end
    end

endmodule

// File: tb/tb_pg_bus_reader.sv
// Bench for pg_bus_reader: directed reads with a scoreboard queue of expected words
// checked by an independent monitor on each DVALID rise.
module tb_pg_bus_reader;

    logic       clk = 1'b0;
    logic       rst, rd_req, dready, bus_in;
    logic       rd_busy, dvalid, gate_n, gate_p, drv;
    logic [7:0] dout;

    logic       c_req, c_ready, c_bus;
    logic       c_busy, c_dvalid, c_gn, c_gp, c_drv;
    logic [0:0] c_dout;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];
    logic       dv_prev = 1'b0;

    always #5 clk = ~clk;

    pg_bus_reader dut (
        .CLK(clk), .RST(rst), .RD_REQ(rd_req), .RD_BUSY(rd_busy), .DOUT(dout),
        .DVALID(dvalid), .DREADY(dready), .GATE_N(gate_n), .GATE_P(gate_p),
        .DRV(drv), .BUS_IN(bus_in)
    );

    pg_bus_reader #(.WIDTH(1), .BITCYC(2), .SAMPLE(1), .TURN(1)) dut_c (
        .CLK(clk), .RST(rst), .RD_REQ(c_req), .RD_BUSY(c_busy), .DOUT(c_dout),
        .DVALID(c_dvalid), .DREADY(c_ready), .GATE_N(c_gn), .GATE_P(c_gp),
        .DRV(c_drv), .BUS_IN(c_bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new DVALID presentation consumes one expected word
    always @(negedge clk) begin
        if (!rst && dvalid && !dv_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_dvalid: got dout %0h expected no word", dout);
            end else begin
                chk("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        dv_prev = dvalid;
    end

    // mode 0: line carries data MSB first; 1: pulse at slot clock 2 only; 2: pulse at slot clock 3 only
    task automatic do_read(input logic [7:0] data, input int mode, input int abort_k, input bit toggle);
        int b, sc;
        if (abort_k == 0) exp_q.push_back(data);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("start_gate_n", 32'(gate_n), 1);
        chk("start_gate_p", 32'(gate_p), 0);
        chk("start_drv", 32'(drv), 0);
        chk("start_busy", 32'(rd_busy), 1);
        for (int k = 1; k <= 38; k++) begin
            bus_in = 1'b0;
            if (k >= 7) begin
                b  = (k - 7) / 4;
                sc = (k - 7) % 4;
                case (mode)
                    0:       bus_in = data[7 - b];
                    1:       bus_in = (sc == 2);
                    default: bus_in = (sc == 3);
                endcase
                if (toggle) rd_req = (k % 2 == 1);
            end
            if (k == abort_k) rst = 1'b1;
            tick();
            if (k == abort_k) begin
                chk("abort_gate_n", 32'(gate_n), 0);
                chk("abort_gate_p", 32'(gate_p), 1);
                chk("abort_drv", 32'(drv), 1);
                chk("abort_dvalid", 32'(dvalid), 0);
                chk("abort_dout", 32'(dout), 0);
                chk("abort_busy", 32'(rd_busy), 0);
                rst    = 1'b0;
                rd_req = 1'b0;
                bus_in = 1'b0;
                return;
            end
            chk("gate_n_seq", 32'(gate_n), 32'(k < 4));
            chk("gate_p_seq", 32'(gate_p), 32'(k >= 4));
            chk("dvalid_seq", 32'(dvalid), 32'(k == 38));
            chk("busy_seq", 32'(rd_busy), 1);
        end
        rd_req = 1'b0;
        bus_in = 1'b0;
    endtask

    task automatic accept(input logic [7:0] data, input int hold);
        dready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            rd_req = (i % 2 == 0);
            tick();
            chk("hold_dvalid", 32'(dvalid), 1);
            chk("hold_dout", 32'(dout), 32'(data));
            chk("hold_busy", 32'(rd_busy), 1);
            chk("hold_gate_n", 32'(gate_n), 0);
        end
        rd_req = 1'b0;
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("accept_busy", 32'(rd_busy), 0);
        chk("accept_dvalid", 32'(dvalid), 0);
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b1; dready = 1'b1; bus_in = 1'b0;
        c_req = 1'b1; c_ready = 1'b1; c_bus = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy", 32'(rd_busy), 0);
            chk("rst_dvalid", 32'(dvalid), 0);
            chk("rst_dout", 32'(dout), 0);
            chk("rst_gate_n", 32'(gate_n), 0);
            chk("rst_gate_p", 32'(gate_p), 1);
            chk("rst_drv", 32'(drv), 1);
            chk("rst_c_gate_n", 32'(c_gn), 0);
        end
        rst = 1'b0; rd_req = 1'b0; dready = 1'b0;
        c_req = 1'b0; c_ready = 1'b0;
        tick();

        do_read(8'hA5, 0, 0, 1'b0);
        accept(8'hA5, 0);
        do_read(8'hFF, 1, 0, 1'b0);
        accept(8'hFF, 0);
        do_read(8'h00, 2, 0, 1'b0);
        accept(8'h00, 0);

        do_read(8'h5A, 0, 0, 1'b1);
        accept(8'h5A, 10);
        do_read(8'h96, 0, 0, 1'b0);
        accept(8'h96, 0);

        do_read(8'hC3, 0, 16, 1'b0);
        tick();
        do_read(8'h3C, 0, 0, 1'b0);
        accept(8'h3C, 0);

        // Minimal-parameter instance: line high only before the single sample edge
        c_req = 1'b1;
        tick();
        c_req = 1'b0;
        chk("c_start_gate_n", 32'(c_gn), 1);
        for (int k = 1; k <= 5; k++) begin
            c_bus = (k == 5);
            tick();
            chk("c_gate_n_seq", 32'(c_gn), 32'(k < 2));
            chk("c_dvalid_seq", 32'(c_dvalid), 32'(k == 5));
        end
        c_bus = 1'b0;
        chk("c_dout", 32'(c_dout), 1);
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        chk("c_accept_dvalid", 32'(c_dvalid), 0);
        chk("c_accept_busy", 32'(c_busy), 0);

        tick();
        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
